// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the multi-channel register bank.
// Register map offsets, CTRL bit positions and the access decode type.
package reg_bank_pkg;

    localparam int ADDR_CTRL         = 0;
    localparam int ADDR_INT_MASK     = 1;
    localparam int ADDR_INT_STATUS   = 2;
    localparam int ADDR_ID           = 3;
    localparam int ADDR_PKT_CNT_BASE = 4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_SCLR = 1;

    localparam logic [7:0] REG_BANK_ID = 8'hA5;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_RD,
        ACC_WR,
        ACC_ERR
    } acc_t;

endpackage

// File: rtl/reg_event_ctr.sv
// Saturating per-channel packet counter with clear-on-read.
// Precedence: soft clear, then clear-on-read (reloads with the
// coincident increment), then increment.
module reg_event_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr_rd,
    input  logic         i_sclr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_sat;

    assign w_sat = &r_cnt;
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_sclr) begin
            r_cnt <= '0;
        end else if (i_clr_rd) begin
            r_cnt <= W'(i_inc);
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/reg_bank_mch.sv
// Register bank for NUM_CH receive channels: control, mask, W1C
// status, ID and clear-on-read packet counters, plus the interrupt.
module reg_bank_mch
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              acc_err,
    output logic              int_n,
    input  logic [NUM_CH-1:0] ch_event,
    output logic              cfg_enable,
    output logic [NUM_CH-1:0] cfg_mask
);

    localparam int AW1 = ADDR_W + 1;

    acc_t              w_acc;
    logic [AW1-1:0]    w_addr_x;
    logic              w_is_ctrl;
    logic              w_is_mask;
    logic              w_is_stat;
    logic              w_is_id;
    logic [NUM_CH-1:0] w_sel;
    logic              w_is_cnt;
    logic              w_writable;
    logic              w_mapped;
    logic              w_do_wr;
    logic              w_do_rd;
    logic              w_err;
    logic              w_sclr;
    logic [NUM_CH-1:0] w_w1c;
    logic [NUM_CH-1:0] w_ev;
    logic [NUM_CH-1:0] w_clr_rd;
    logic [DATA_W-1:0] w_rd_val;
    logic [DATA_W-1:0] w_cnt [NUM_CH];
    logic              w_unused_wdata;

    logic              r_en;
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] r_status;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_acc_err;
    logic              r_int_n;

    always_comb begin
        w_acc = ACC_NONE;
        case ({wr, rd})
            2'b11:   w_acc = ACC_ERR;
            2'b10:   w_acc = ACC_WR;
            2'b01:   w_acc = ACC_RD;
            default: w_acc = ACC_NONE;
        endcase
    end

    assign w_addr_x  = {1'b0, addr};
    assign w_is_ctrl = (addr == ADDR_W'(ADDR_CTRL));
    assign w_is_mask = (addr == ADDR_W'(ADDR_INT_MASK));
    assign w_is_stat = (addr == ADDR_W'(ADDR_INT_STATUS));
    assign w_is_id   = (addr == ADDR_W'(ADDR_ID));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_sel
        assign w_sel[c] =
            (w_addr_x == AW1'(ADDR_PKT_CNT_BASE + c));
    end

    assign w_is_cnt   = |w_sel;
    assign w_writable = w_is_ctrl | w_is_mask | w_is_stat;
    assign w_mapped   = w_writable | w_is_id | w_is_cnt;

    assign w_do_wr = (w_acc == ACC_WR) && w_writable;
    assign w_do_rd = (w_acc == ACC_RD);
    assign w_err   = (w_acc == ACC_ERR)
                   | ((w_acc == ACC_WR) && !w_writable)
                   | ((w_acc == ACC_RD) && !w_mapped);

    assign w_sclr   = w_do_wr && w_is_ctrl && wr_data[CTRL_SCLR];
    assign w_w1c    = (w_do_wr && w_is_stat) ?
                      wr_data[NUM_CH-1:0] : '0;
    assign w_ev     = ch_event & {NUM_CH{r_en}};
    assign w_clr_rd = w_sel & {NUM_CH{w_do_rd}};

    assign w_unused_wdata = ^wr_data;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ctr
        reg_event_ctr #(
            .W (DATA_W)
        ) u_ctr (
            .clk      (clk),
            .rst      (rst),
            .i_inc    (w_ev[c]),
            .i_clr_rd (w_clr_rd[c]),
            .i_sclr   (w_sclr),
            .o_cnt    (w_cnt[c])
        );
    end

    // Unmapped addresses fall through to zero.
    always_comb begin
        w_rd_val = '0;
        unique case (1'b1)
            w_is_ctrl: w_rd_val = DATA_W'(r_en);
            w_is_mask: w_rd_val = DATA_W'(r_mask);
            w_is_stat: w_rd_val = DATA_W'(r_status);
            w_is_id:   w_rd_val = DATA_W'(REG_BANK_ID);
            w_is_cnt: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_sel[c]) w_rd_val = w_cnt[c];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en       <= 1'b0;
            r_mask     <= '0;
            r_status   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_acc_err  <= 1'b0;
            r_int_n    <= 1'b1;
        end else begin
            r_rd_valid <= w_do_rd;
            r_acc_err  <= w_err;
            if (w_do_rd) r_rd_data <= w_rd_val;
            if (w_do_wr && w_is_ctrl) r_en <= wr_data[CTRL_EN];
            if (w_do_wr && w_is_mask)
                r_mask <= wr_data[NUM_CH-1:0];
            // A new event beats a coincident W1C of the same bit.
            if (w_sclr) r_status <= '0;
            else r_status <= (r_status & ~w_w1c) | w_ev;
            r_int_n <= ~(r_en & |(r_status & r_mask));
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign acc_err    = r_acc_err;
    assign int_n      = r_int_n;
    assign cfg_enable = r_en;
    assign cfg_mask   = r_mask;

endmodule

// File: doc/reg_bank_mch.md
Name: reg_bank_mch

Overview:
- Parametrised register bank, successor to the fixed 3-bit-address / 8-bit-data single-interrupt register port.
- Serves NUM_CH receive channels of the packet divider/reorder datapath.
- Holds control, interrupt mask and W1C interrupt status, plus per-channel clear-on-read packet-available counters.
- Drives one registered active-low interrupt and flags illegal accesses. Sits between the register agent bus and the datapath.

Parameters:
- ADDR_W, 4, address width; must satisfy 4+NUM_CH <= 2**ADDR_W.
- DATA_W, 8, register data width; must satisfy NUM_CH <= DATA_W.
- NUM_CH, 4, number of receive channels (1..DATA_W).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- addr  in  ADDR_W  register address, sampled with wr/rd.
- wr  in  1  write strobe, one access per cycle.
- wr_data  in  DATA_W  write data.
- rd  in  1  read strobe.
- rd_data  out  DATA_W  read data, registered.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- acc_err  out  1  one-cycle pulse: illegal access.
- int_n  out  1  active-low interrupt, registered.
- ch_event  in  NUM_CH  per-channel one-cycle "packet available" pulses.
- cfg_enable  out  1  CTRL.EN to datapath.
- cfg_mask  out  NUM_CH  INT_MASK to datapath.

Behaviour:
- Reset (async, rst=1):
  - Outputs: rd_data=0, rd_valid=0, acc_err=0, int_n=1, cfg_enable=0, cfg_mask=0.
  - State: all counters=0, INT_STATUS=0, CTRL=0, INT_MASK=0.
  - Reset asserted mid-access aborts the access; no rd_valid follows.
- Register map:
  - 0x0 CTRL (RW): bit0 EN; bit1 SCLR is self-clearing (write 1 zeroes all counters and INT_STATUS next edge; reads as 0). Other bits read 0.
  - 0x1 INT_MASK (RW): [NUM_CH-1:0]; 1 = channel enabled to interrupt.
  - 0x2 INT_STATUS (W1C): [NUM_CH-1:0], sticky.
  - 0x3 ID (RO): constant REG_BANK_ID, zero-extended/truncated to DATA_W.
  - 0x4+c PKT_CNT[c] (RO, clear-on-read): c = 0..NUM_CH-1.
  - Any other address is unmapped.
- Write:
  - Takes effect at the clk edge where wr=1.
  - Write to a RO register or an unmapped address: no state change; acc_err=1 next cycle.
- Read:
  - rd=1 at edge N gives rd_data plus rd_valid=1 at edge N+1 (latency 1).
  - rd_data holds its last value when rd_valid=0.
  - Unmapped read returns 0 with rd_valid=1 and acc_err=1.
- rd and wr both high: neither performed; acc_err=1 next cycle, rd_valid=0.
- Events:
  - With EN=1, ch_event[c] increments PKT_CNT[c], saturating at 2**DATA_W-1, and sets INT_STATUS[c].
  - With EN=0, events are ignored.
- Simultaneous events:
  - Read of PKT_CNT[c] together with ch_event[c]: returns the old value; counter becomes 1.
  - W1C of bit c together with ch_event[c]: set wins, bit stays 1.
  - SCLR together with an event: clear wins.
- Interrupt:
  - int_n <= ~(EN & |(INT_STATUS & INT_MASK)), registered.
  - Deasserts one cycle after the clearing write or mask change.
  - Event at edge N drives int_n low after edge N+1.

Decomposition:
- Package reg_bank_pkg:
  - Address constants ADDR_CTRL=0, ADDR_INT_MASK=1, ADDR_INT_STATUS=2, ADDR_ID=3, ADDR_PKT_CNT_BASE=4.
  - Bit positions CTRL_EN=0, CTRL_SCLR=1.
  - REG_BANK_ID=8'hA5.
  - typedef enum for access decode: ACC_NONE, ACC_RD, ACC_WR, ACC_ERR.
- Sub-module reg_event_ctr: one per channel via generate. Saturating counter with inc, clr_on_rd and sclr inputs, following the precedence above.

Test Plan:
- Reset, then read 0x3 -> rd_valid one cycle after rd, rd_data=0xA5, int_n=1, acc_err=0.
- Write CTRL=0x01, INT_MASK=0x04, pulse ch_event[2] three times -> int_n low two cycles after first pulse; read 0x6 returns 3; read again returns 0.
- Write INT_STATUS=0x04 in the same cycle as ch_event[2] -> status bit 2 stays 1, int_n stays 0; next W1C alone -> int_n=1 one cycle later.
- EN=1, 260 pulses on ch_event[0] with DATA_W=8 -> PKT_CNT[0] reads 255 (saturates); pulses with EN=0 -> count unchanged.
- wr and rd together at 0x1; write to 0x3; read 0xF -> each gives acc_err pulse; INT_MASK unchanged; 0xF read gives rd_data=0.
- Assert rst mid-read and during int_n=0 -> outputs return to reset values immediately; no rd_valid after release.
